// File: rtl/pipe_ctrl.sv
// Hold/flush/redirect controller for the in-order RISC-V pipeline.
// Optional divide watchdog enabled by defining PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl #(
    parameter int            AW           = 32,
    parameter int            FLUSH_CYCLES = 2,
    parameter logic [AW-1:0] RESET_ADDR   = {AW{1'b0}},
    parameter int            DIV_TIMEOUT  = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          jump_en_i,
    input  logic [AW-1:0] jump_addr_i,
    input  logic          load_use_i,
    input  logic          div_start_i,
    input  logic          div_done_i,
    output logic          pc_load_o,
    output logic [AW-1:0] pc_addr_o,
    output logic          hold_if_o,
    output logic          hold_id_o,
    output logic          flush_if_o,
    output logic          flush_id_o,
    output logic          div_kill_o,
    output logic          busy_o,
    output logic          err_o
);

    typedef enum logic [1:0] {IDLE, FLUSH, DIV_WAIT} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam int WD_W = ($clog2(DIV_TIMEOUT + 1) > 7) ? $clog2(DIV_TIMEOUT + 1) : 7;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(DIV_TIMEOUT - 1);
    logic [WD_W-1:0] wd;
`else
    assign err_o = 1'b0;
`endif

    // Holds are combinational so the stall lands in the same cycle as the hazard.
    always_comb begin
        hold_if_o = 1'b0;
        hold_id_o = 1'b0;
        case (state)
            IDLE: hold_if_o = load_use_i && !jump_en_i && !div_start_i;
            DIV_WAIT: begin
                hold_if_o = !div_done_i;
                hold_id_o = !div_done_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            pc_addr_o  <= RESET_ADDR;
            pc_load_o  <= 1'b0;
            flush_if_o <= 1'b0;
            flush_id_o <= 1'b0;
            div_kill_o <= 1'b0;
            busy_o     <= 1'b0;
`ifdef PIPE_CTRL_TIMEOUT_EN
            wd         <= '0;
            err_o      <= 1'b0;
`endif
        end else begin
            pc_load_o  <= 1'b0;
            flush_if_o <= 1'b0;
            flush_id_o <= 1'b0;
            div_kill_o <= 1'b0;
            // A redirect wins in every state; from DIV_WAIT it also aborts the divider.
            if (jump_en_i) begin
                state      <= FLUSH;
                cnt        <= CNT_LOAD;
                pc_addr_o  <= jump_addr_i;
                pc_load_o  <= 1'b1;
                flush_if_o <= 1'b1;
                flush_id_o <= 1'b1;
                busy_o     <= 1'b1;
                if (state == DIV_WAIT)
                    div_kill_o <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (div_start_i) begin
                            state  <= DIV_WAIT;
                            busy_o <= 1'b1;
`ifdef PIPE_CTRL_TIMEOUT_EN
                            wd     <= '0;
`endif
                        end else begin
                            busy_o <= 1'b0;
                            if (load_use_i)
                                flush_id_o <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (cnt == 4'd0) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end else begin
                            cnt        <= cnt - 4'd1;
                            flush_if_o <= 1'b1;
                            flush_id_o <= 1'b1;
                            busy_o     <= 1'b1;
                        end
                    end
                    DIV_WAIT: begin
                        if (div_done_i) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
`ifdef PIPE_CTRL_TIMEOUT_EN
                        else if (wd == WD_LIMIT) begin
                            state      <= IDLE;
                            busy_o     <= 1'b0;
                            div_kill_o <= 1'b1;
                            err_o      <= 1'b1;
                        end else begin
                            wd <= wd + 1'b1;
                        end
`endif
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        load_use_i;
    logic        div_start_i;
    logic        div_done_i;
    logic        pc_load_o;
    logic [31:0] pc_addr_o;
    logic        hold_if_o;
    logic        hold_id_o;
    logic        flush_if_o;
    logic        flush_id_o;
    logic        div_kill_o;
    logic        busy_o;
    logic        err_o;

    int vectors = 0;
    int miscompares = 0;

    pipe_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .jump_en_i  (jump_en_i),
        .jump_addr_i(jump_addr_i),
        .load_use_i (load_use_i),
        .div_start_i(div_start_i),
        .div_done_i (div_done_i),
        .pc_load_o  (pc_load_o),
        .pc_addr_o  (pc_addr_o),
        .hold_if_o  (hold_if_o),
        .hold_id_o  (hold_id_o),
        .flush_if_o (flush_if_o),
        .flush_id_o (flush_id_o),
        .div_kill_o (div_kill_o),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic j, input logic [31:0] a, input logic lu,
                         input logic ds, input logic dd);
        jump_en_i   = j;
        jump_addr_i = a;
        load_use_i  = lu;
        div_start_i = ds;
        div_done_i  = dd;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_pc_load"}, {31'd0, pc_load_o}, 32'd0);
        check({tag, "_flush_if"}, {31'd0, flush_if_o}, 32'd0);
        check({tag, "_flush_id"}, {31'd0, flush_id_o}, 32'd0);
        check({tag, "_div_kill"}, {31'd0, div_kill_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_err"}, {31'd0, err_o}, 32'd0);
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 32'h0, 0, 0, 0);

        // Reset held for 3 cycles while inputs toggle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hdead_0000 + 32'(i), i[0], ~i[0], 1'b1);
            tick();
            check("rst_pc_addr", pc_addr_o, 32'h0);
            check_quiet("rst");
        end
        drive(0, 32'h0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        check("idle_hold_if", {31'd0, hold_if_o}, 32'd0);
        check("idle_hold_id", {31'd0, hold_id_o}, 32'd0);
        check_quiet("idle");

        // Redirect from IDLE
        drive(1, 32'h0000_0100, 0, 0, 0);
        check("jmp_hold_if", {31'd0, hold_if_o}, 32'd0);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        check("jmp_pc_load", {31'd0, pc_load_o}, 32'd1);
        check("jmp_pc_addr", pc_addr_o, 32'h100);
        check("jmp_flush_if1", {31'd0, flush_if_o}, 32'd1);
        check("jmp_flush_id1", {31'd0, flush_id_o}, 32'd1);
        check("jmp_busy1", {31'd0, busy_o}, 32'd1);
        tick();
        check("jmp_pc_load2", {31'd0, pc_load_o}, 32'd0);
        check("jmp_flush_if2", {31'd0, flush_if_o}, 32'd1);
        check("jmp_flush_id2", {31'd0, flush_id_o}, 32'd1);
        tick();
        check("jmp_flush_if3", {31'd0, flush_if_o}, 32'd0);
        check("jmp_flush_id3", {31'd0, flush_id_o}, 32'd0);
        check("jmp_busy3", {31'd0, busy_o}, 32'd0);
        check("jmp_pc_hold", pc_addr_o, 32'h100);

        // Load-use hazard in IDLE
        drive(0, 32'h0, 1, 0, 0);
        check("lu_hold_if", {31'd0, hold_if_o}, 32'd1);
        check("lu_hold_id", {31'd0, hold_id_o}, 32'd0);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        check("lu_flush_id1", {31'd0, flush_id_o}, 32'd1);
        check("lu_flush_if1", {31'd0, flush_if_o}, 32'd0);
        check("lu_busy1", {31'd0, busy_o}, 32'd0);
        tick();
        check("lu_flush_id2", {31'd0, flush_id_o}, 32'd0);

        // Divide: start at t0, done at t10
        drive(0, 32'h0, 0, 1, 0);
        check("div_t0_hold_if", {31'd0, hold_if_o}, 32'd0);
        tick();
        drive(0, 32'h0, 1, 1, 0);
        for (int t = 1; t <= 9; t++) begin
            check("div_hold_if", {31'd0, hold_if_o}, 32'd1);
            check("div_hold_id", {31'd0, hold_id_o}, 32'd1);
            check("div_busy", {31'd0, busy_o}, 32'd1);
            check("div_flush_id", {31'd0, flush_id_o}, 32'd0);
            tick();
        end
        drive(0, 32'h0, 0, 0, 1);
        check("div_t10_hold_if", {31'd0, hold_if_o}, 32'd0);
        check("div_t10_hold_id", {31'd0, hold_id_o}, 32'd0);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        check("div_t11_busy", {31'd0, busy_o}, 32'd0);
        check("div_t11_hold_if", {31'd0, hold_if_o}, 32'd0);
        check("div_t11_flush_id", {31'd0, flush_id_o}, 32'd0);

        // Jump during DIV_WAIT with concurrent load-use
        drive(0, 32'h0, 0, 1, 0);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        tick();
        drive(1, 32'h0000_0200, 1, 0, 0);
        check("jd_hold_if", {31'd0, hold_if_o}, 32'd1);
        tick();
        drive(0, 32'h0, 1, 1, 0);
        check("jd_div_kill", {31'd0, div_kill_o}, 32'd1);
        check("jd_pc_load", {31'd0, pc_load_o}, 32'd1);
        check("jd_pc_addr", pc_addr_o, 32'h200);
        check("jd_flush_if1", {31'd0, flush_if_o}, 32'd1);
        check("jd_flush_id1", {31'd0, flush_id_o}, 32'd1);
        check("jd_hold_if_flush", {31'd0, hold_if_o}, 32'd0);
        check("jd_hold_id_flush", {31'd0, hold_id_o}, 32'd0);
        tick();
        drive(0, 32'h0, 1, 0, 1);
        check("jd_div_kill2", {31'd0, div_kill_o}, 32'd0);
        check("jd_flush_if2", {31'd0, flush_if_o}, 32'd1);
        check("jd_hold_if2", {31'd0, hold_if_o}, 32'd0);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        check("jd_flush_id3", {31'd0, flush_id_o}, 32'd0);
        check("jd_flush_if3", {31'd0, flush_if_o}, 32'd0);
        check("jd_busy3", {31'd0, busy_o}, 32'd0);

        // Re-trigger inside FLUSH; jump also beats a simultaneous div_start
        drive(1, 32'h0000_0300, 0, 1, 0);
        tick();
        drive(1, 32'h0000_0400, 0, 0, 0);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        check("rt_pc_load", {31'd0, pc_load_o}, 32'd1);
        check("rt_pc_addr", pc_addr_o, 32'h400);
        check("rt_div_kill", {31'd0, div_kill_o}, 32'd0);
        tick();
        check("rt_flush_if2", {31'd0, flush_if_o}, 32'd1);
        tick();
        check("rt_flush_if3", {31'd0, flush_if_o}, 32'd0);
        check("rt_busy3", {31'd0, busy_o}, 32'd0);
        check("rt_hold_if3", {31'd0, hold_if_o}, 32'd0);

        // Long divide: watchdog behaviour depends on build option
        drive(0, 32'h0, 0, 1, 0);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        for (int t = 1; t < 64; t++) tick();
        check("wd_t64_hold_if", {31'd0, hold_if_o}, 32'd1);
        check("wd_t64_div_kill", {31'd0, div_kill_o}, 32'd0);
        tick();
`ifdef PIPE_CTRL_TIMEOUT_EN
        check("wd_kill", {31'd0, div_kill_o}, 32'd1);
        check("wd_err", {31'd0, err_o}, 32'd1);
        check("wd_busy", {31'd0, busy_o}, 32'd0);
        check("wd_hold_if", {31'd0, hold_if_o}, 32'd0);
        tick();
        check("wd_kill2", {31'd0, div_kill_o}, 32'd0);
        check("wd_err_sticky", {31'd0, err_o}, 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("wd_err_cleared", {31'd0, err_o}, 32'd0);
`else
        for (int t = 0; t < 8; t++) tick();
        check("nowd_hold_if", {31'd0, hold_if_o}, 32'd1);
        check("nowd_busy", {31'd0, busy_o}, 32'd1);
        check("nowd_div_kill", {31'd0, div_kill_o}, 32'd0);
        check("nowd_err", {31'd0, err_o}, 32'd0);
        drive(0, 32'h0, 0, 0, 1);
        tick();
        drive(0, 32'h0, 0, 0, 0);
        check("nowd_done_busy", {31'd0, busy_o}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
